im_fetch_unit: RTL

Fetch sequencer for the asynchronous-read instruction memory (IM). It owns the program counter, drives the IM word address, and captures each returned instruction together with its PC into a small buffer. The buffer feeds decode through a valid/ready handshake. Branch/jump redirect, halt and address-fault detection are handled here, so the IM itself stays a pure combinational ROM.

---
 rtl/cpu_pkg.sv | 17 +
 rtl/fetch_buf.sv | 58 +++++
 rtl/im_fetch_unit.sv | 105 ++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU constants and types: IM placement, fetch FSM states and
// the {pc, instr} record carried by the fetch buffer.
package cpu_pkg;
    localparam logic [31:0] RESET_PC = 32'h0000_3000;
    localparam logic [31:0] IM_BASE  = 32'h0000_3000;

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_HALTED = 2'd1,
        ST_FAULT  = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_buf.sv
// Small synchronous FIFO of fetched {pc, instr} entries; flush wins over
// push/pop, and the head reads as zero whenever the FIFO is empty.
module fetch_buf
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic          i_flush,
    input  fetch_entry_t  i_wr_data,
    output fetch_entry_t  o_head,
    output logic [CW-1:0] o_count,
    output logic          o_full,
    output logic          o_empty
);
    fetch_entry_t  r_mem [DEPTH];
    logic [PW-1:0] r_rd_ptr, r_wr_ptr;
    logic [CW-1:0] r_count;
    logic          w_do_pop, w_do_push;

    assign o_count   = r_count;
    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_head    = o_empty ? '0 : r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    // When full, the slot being popped this edge is the one overwritten.
    assign w_do_push = i_push && (!o_full || w_do_pop);

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_do_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            if (w_do_push && !w_do_pop)      r_count <= r_count + CW'(1);
            else if (w_do_pop && !w_do_push) r_count <= r_count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!i_flush && w_do_push) r_mem[r_wr_ptr] <= i_wr_data;
    end
endmodule

// File: rtl/im_fetch_unit.sv
// Instruction fetch sequencer: owns the PC, addresses the combinational IM,
// buffers {pc, instr} for decode and handles redirect, halt and address faults.
module im_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = cpu_pkg::RESET_PC,
    parameter logic [31:0] IM_BASE   = cpu_pkg::IM_BASE,
    parameter int          IM_WORDS  = 1024,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] ImAddr_o,
    input  logic [31:0] Instr_i,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        halt_i,
    output logic        inst_valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] inst_pc_o,
    input  logic        inst_ready_i,
    output logic        fault_o,
    output logic [31:0] fault_pc_o,
    output logic        halted_o
);
    localparam int CW = $clog2(BUF_DEPTH + 1);

    fetch_state_e  r_state, w_state_nxt;
    logic [31:0]   r_pc, r_fault_pc;
    logic          r_fault;
    logic          w_pc_ok, w_pop, w_push, w_full, w_empty;
    logic [32:0]   w_pc33, w_lo33, w_hi33;
    logic [CW-1:0] w_count;
    fetch_entry_t  w_head, w_wr;

    // 33-bit bounds so IM_BASE + 4*IM_WORDS cannot wrap.
    assign w_pc33  = {1'b0, r_pc};
    assign w_lo33  = {1'b0, IM_BASE};
    assign w_hi33  = w_lo33 + 33'(4 * IM_WORDS) - 33'd4;
    assign w_pc_ok = (r_pc[1:0] == 2'b00) && (w_pc33 >= w_lo33) && (w_pc33 <= w_hi33);

    assign w_pop  = inst_valid_o && inst_ready_i;
    assign w_push = (r_state == ST_FETCH) && w_pc_ok && !redirect_valid_i && !halt_i
                    && (!w_full || w_pop);
    assign w_wr   = '{pc: r_pc, instr: Instr_i};

    fetch_buf #(.DEPTH(BUF_DEPTH)) u_buf (
        .clk       (clk),
        .rst       (rst),
        .i_push    (w_push),
        .i_pop     (w_pop),
        .i_flush   (redirect_valid_i),
        .i_wr_data (w_wr),
        .o_head    (w_head),
        .o_count   (w_count),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );

    assign ImAddr_o     = r_pc;
    assign inst_valid_o = !w_empty;
    assign inst_o       = w_head.instr;
    assign inst_pc_o    = w_head.pc;
    assign fault_o      = r_fault;
    assign fault_pc_o   = r_fault_pc;
    assign halted_o     = (r_state == ST_HALTED);

    always_comb begin
        w_state_nxt = r_state;
        if (redirect_valid_i) begin
            w_state_nxt = halt_i ? ST_HALTED : ST_FETCH;
        end else begin
            case (r_state)
                ST_FETCH:  if (!w_pc_ok)     w_state_nxt = ST_FAULT;
                           else if (halt_i)  w_state_nxt = ST_HALTED;
                ST_HALTED: if (!halt_i)      w_state_nxt = ST_FETCH;
                ST_FAULT:                    w_state_nxt = ST_FAULT;
                default:                     w_state_nxt = ST_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_FETCH;
            r_pc       <= RESET_PC;
            r_fault    <= 1'b0;
            r_fault_pc <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (redirect_valid_i) begin
                r_pc    <= redirect_pc_i;
                r_fault <= 1'b0;
            end else if (r_state == ST_FETCH && !w_pc_ok) begin
                r_fault    <= 1'b1;
                r_fault_pc <= r_pc;
            end else if (w_push) begin
                r_pc <= r_pc + 32'd4;
            end
        end
    end

    logic w_unused;
    assign w_unused = ^w_count;
endmodule
